// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte pending slot.
// Parameters:
//   UART_BPS     - serial bit rate
//   CLK_FREQ     - sys_clk frequency in Hz
//   BAUD_CNT_MAX - sys_clk cycles per serial bit
// Ports:
//   sys_clk   - system clock
//   sys_rst_n - asynchronous active-low reset
//   tx_data   - byte to send, valid together with tx_flag
//   tx_flag   - request strobe, one request per high cycle
//   tx        - serial line, idle high
//   tx_busy   - high while a frame is on the line
//   tx_done   - one-cycle pulse on the last stop-bit cycle
//   overrun   - sticky, set when a request is dropped
module uart_tx #(
  parameter int unsigned UART_BPS     = 9600,
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_flag,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overrun
);

  localparam int unsigned CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic bit_end_c;
  logic last_stop_c;

  assign bit_end_c   = (cnt_q == CNT_LAST);
  assign last_stop_c = (state_q == STOP) && bit_end_c;

  // State register and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state, pending slot and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovr_d    = ovr_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_flag) begin
          state_d = START;
          data_d  = tx_data;
        end
      end
      START: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          cnt_d = '0;
          idx_d = '0;
          if (pend_v_q) begin
            // Pending byte goes out next; a simultaneous request refills the slot
            state_d  = START;
            data_d   = pend_q;
            pend_v_d = tx_flag;
            if (tx_flag) begin
              pend_d = tx_data;
            end
          end else if (tx_flag) begin
            state_d = START;
            data_d  = tx_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Requests arriving mid-frame fill the slot or are dropped
    if ((state_q != IDLE) && !last_stop_c && tx_flag) begin
      if (!pend_v_q) begin
        pend_d   = tx_data;
        pend_v_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // Outputs are decoded from the next state so the registers match it
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx, run with a short bit time.
module tb_uart_tx;

  localparam int unsigned B     = 16;
  localparam int unsigned FRAME = 10 * B;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_flag   = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .UART_BPS     (9600),
    .CLK_FREQ     (50_000_000),
    .BAUD_CNT_MAX (B)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_data   (tx_data),
    .tx_flag   (tx_flag),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .overrun   (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  // Receiver model: samples mid-bit on the falling clock edge
  logic       rx_prev = 1'b1;
  logic       rx_on   = 1'b0;
  int         rx_cnt  = 0;
  int         rx_bit;
  logic [9:0] rx_sh   = '0;
  int         rx_ferr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  assign rx_bit = rx_cnt / B;

  always @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_on   <= 1'b0;
      rx_prev <= 1'b1;
      rx_cnt  <= 0;
    end else begin
      rx_prev <= tx;
      if (!rx_on) begin
        if (rx_prev && !tx) begin
          rx_on  <= 1'b1;
          rx_cnt <= 1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1;
        if ((rx_cnt % B) == (B / 2)) begin
          if (rx_bit == 0) begin
            if (tx) begin
              rx_ferr <= rx_ferr + 1;
              rx_on   <= 1'b0;
            end
          end else if (rx_bit < 9) begin
            rx_sh[4'(rx_bit)] <= tx;
          end else begin
            if (!tx) rx_ferr <= rx_ferr + 1;
            rx_q.push_back(rx_sh[8:1]);
            rx_on <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Wait for a tx_done pulse, bounded by budget cycles
  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!tx_done && n < budget) begin
      tick();
      n++;
    end
    chk({nm, " done seen"}, longint'(tx_done), 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (tx_busy && n < budget) begin
      tick();
      n++;
    end
    chk({nm, " idle reached"}, longint'(tx_busy), 0);
  endtask

  // Send one byte from idle and check the full line waveform cycle by cycle
  task automatic run_single(input logic [7:0] d, input logic [9:0] fr, input string nm);
    int         mism     = 0;
    int         done_cnt = 0;
    int         done_at  = -1;
    int         busy_bad = 0;
    logic [9:0] got      = '0;
    tx_data = d;
    tx_flag = 1'b1;
    tick();
    tx_flag = 1'b0;
    tx_data = ~d;
    exp_q.push_back(d);
    for (int k = 0; k < int'(FRAME); k++) begin
      if (tx !== fr[4'(k / B)]) mism++;
      if ((k % B) == (B / 2)) got[4'(k / B)] = tx;
      if (tx_done) begin
        done_cnt++;
        done_at = k;
      end
      if (!tx_busy) busy_bad++;
      tick();
    end
    chk({nm, " frame bits"}, longint'(got), longint'(fr));
    chk({nm, " waveform mismatches"}, mism, 0);
    chk({nm, " done pulses"}, done_cnt, 1);
    chk({nm, " done position"}, done_at, FRAME - 1);
    chk({nm, " busy gaps"}, busy_bad, 0);
    chk({nm, " busy after"}, longint'(tx_busy), 0);
    chk({nm, " tx after"}, longint'(tx), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in send order, bit 0 = start bit
    int         gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int glitch;
    vecs[0] = '{data: 8'hA5, frame: 10'h34A, gap: 3};
    vecs[1] = '{data: 8'h00, frame: 10'h200, gap: 0};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE, gap: 7};
    vecs[3] = '{data: 8'h01, frame: 10'h202, gap: 1};
    vecs[4] = '{data: 8'h3C, frame: 10'h278, gap: 2};

    // Asynchronous reset before any clock edge
    #1 sys_rst_n = 1'b0;
    #1;
    chk("reset tx", longint'(tx), 1);
    chk("reset busy", longint'(tx_busy), 0);
    chk("reset done", longint'(tx_done), 0);
    chk("reset overrun", longint'(overrun), 0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    tick();

    // Table of single frames from idle
    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].gap) tick();
      run_single(vecs[i].data, vecs[i].frame, $sformatf("vec%0d", i));
    end

    // Back-to-back: second byte queued while the first is on the line
    tx_data = 8'h55; tx_flag = 1'b1; tick(); tx_flag = 1'b0;
    exp_q.push_back(8'h55);
    repeat (9) tick();
    tx_data = 8'h0F; tx_flag = 1'b1; tick(); tx_flag = 1'b0;
    exp_q.push_back(8'h0F);
    wait_done("b2b first", FRAME + 4);
    tick();
    chk("b2b start no gap", longint'(tx), 0);
    chk("b2b busy held", longint'(tx_busy), 1);
    chk("b2b done single", longint'(tx_done), 0);
    wait_done("b2b second", FRAME + 4);
    tick();
    chk("b2b busy end", longint'(tx_busy), 0);
    chk("b2b overrun", longint'(overrun), 0);

    // Boundary: request on the tx_done cycle while a byte is pending
    tx_data = 8'h33; tx_flag = 1'b1; tick();
    tx_data = 8'h11; tick(); tx_flag = 1'b0;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h11);
    wait_done("bnd first", FRAME + 4);
    tx_data = 8'h22; tx_flag = 1'b1; tick(); tx_flag = 1'b0; tx_data = 8'h00;
    exp_q.push_back(8'h22);
    chk("bnd pending start", longint'(tx), 0);
    chk("bnd overrun mid", longint'(overrun), 0);
    wait_done("bnd second", FRAME + 4);
    tick();
    chk("bnd refill start", longint'(tx), 0);
    wait_done("bnd third", FRAME + 4);
    tick();
    chk("bnd busy end", longint'(tx_busy), 0);
    chk("bnd overrun", longint'(overrun), 0);

    // Paced source at random phase against a frame already in flight
    tx_data = 8'hC3; tx_flag = 1'b1; tick(); tx_flag = 1'b0;
    exp_q.push_back(8'hC3);
    repeat ($urandom_range(0, FRAME - 2)) tick();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      tx_data = d; tx_flag = 1'b1; tick(); tx_flag = 1'b0;
      exp_q.push_back(d);
      repeat (FRAME - 1) tick();
    end
    wait_idle("paced", 3 * FRAME);
    chk("paced overrun", longint'(overrun), 0);

    // Overrun: three requests in consecutive cycles from idle
    tick();
    tx_data = 8'h01; tx_flag = 1'b1; tick();
    tx_data = 8'h02; tick();
    tx_data = 8'h03; tick();
    tx_flag = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    chk("ovr set", longint'(overrun), 1);
    wait_idle("ovr", 3 * FRAME);
    chk("ovr sticky", longint'(overrun), 1);

    // Reset during data bit 4 of 0x69 (bit 4 is 0)
    tick();
    tx_data = 8'h69; tx_flag = 1'b1; tick(); tx_flag = 1'b0;
    repeat (5 * B + B / 2) tick();
    chk("pre-reset bit4", longint'(tx), 0);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("abort tx", longint'(tx), 1);
    chk("abort busy", longint'(tx_busy), 0);
    chk("abort done", longint'(tx_done), 0);
    chk("abort overrun cleared", longint'(overrun), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    glitch = 0;
    for (int k = 0; k < int'(3 * B); k++) begin
      if (!tx || tx_busy) glitch++;
      tick();
    end
    chk("post-reset line quiet", glitch, 0);
    run_single(8'h3C, 10'h278, "post-reset");

    // Everything the receiver model saw, in order
    repeat (4) tick();
    chk("rx count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk($sformatf("rx byte %0d", i), longint'(rx_q[i]), longint'(exp_q[i]));
    end
    chk("rx framing errors", rx_ferr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
